// File: rtl/controller_pkg.sv
// Shared types and constants for the controller report arbiter.
package controller_pkg;

    // Button bit positions within a frame, MSB first as shifted out of the pad.
    localparam int BTN_A     = 7;
    localparam int BTN_B     = 6;
    localparam int BTN_SEL   = 5;
    localparam int BTN_START = 4;
    localparam int BTN_UP    = 3;
    localparam int BTN_DN    = 2;
    localparam int BTN_L     = 1;
    localparam int BTN_R     = 0;

    localparam int NUM_PORTS         = 2;
    localparam int KEEPALIVE_DEFAULT = 6000000;  // 60 ms at 100 MHz

    typedef logic [7:0] buttons_t;

    typedef enum logic {
        ARB_IDLE,
        ARB_PRESENT
    } arb_state_t;

endpackage

// File: rtl/controller_report_arbiter_if.sv
// Downstream report channel: valid/ready handshake carrying port and buttons.
interface controller_report_arbiter_if;
    import controller_pkg::*;

    logic     m_valid;
    logic     m_ready;
    logic     m_port;
    buttons_t m_buttons;

    modport master (
        output m_valid,
        output m_port,
        output m_buttons,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_port,
        input  m_buttons,
        output m_ready
    );

endinterface

// File: rtl/report_slot.sv
// Per-port frame capture: edge detect, change/keepalive filter, one-deep
// pending buffer, reference of the last granted value and sticky overrun.
module report_slot
    import controller_pkg::*;
#(
    parameter int KEEPALIVE_CYCLES = KEEPALIVE_DEFAULT,
    parameter int CNT_W            = $clog2(KEEPALIVE_CYCLES + 1)
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     i_valid,
    input  buttons_t i_buttons,
    input  logic     i_grant,
    input  logic     i_overrun_clr,
    output logic     o_pending,
    output buttons_t o_pend_buttons,
    output logic     o_overrun
);

    localparam logic [CNT_W-1:0] KA_MAX = CNT_W'(KEEPALIVE_CYCLES);

    logic             r_valid_d;
    logic             r_pending;
    buttons_t         r_pend_buttons;
    buttons_t         r_ref;
    logic             r_overrun;
    logic [CNT_W-1:0] r_ka_cnt;

    logic     w_new_frame;
    logic     w_ka_expired;
    buttons_t w_ref_cmp;
    logic     w_capture;

    assign w_new_frame  = i_valid && !r_valid_d;
    assign w_ka_expired = (r_ka_cnt == KA_MAX);
    // A grant this cycle moves pend_buttons into ref, so compare against the
    // value ref is about to take rather than the stale one.
    assign w_ref_cmp    = i_grant ? r_pend_buttons : r_ref;
    assign w_capture    = w_new_frame && ((i_buttons != w_ref_cmp) || w_ka_expired);

    // Edge detect, pending buffer, reference and overrun tracking.
    always_ff @(posedge clk) begin
        // NOTE: every register here is state; non-blocking assignment keeps
        // all of them updating from the same pre-edge values.
        if (!rst_n) begin
            // NOTE: the pending buffer and reference are reset too, so a reset
            // mid-transfer discards queued reports and re-arms the change filter.
            r_valid_d      <= 1'b0;
            r_pending      <= 1'b0;
            r_pend_buttons <= '0;
            r_ref          <= '0;
            r_overrun      <= 1'b0;
        end else begin
            r_valid_d <= i_valid;

            if (i_grant) begin
                r_ref <= r_pend_buttons;
            end

            // Capture beats grant: the grant took the old value this cycle.
            if (w_capture) begin
                r_pending      <= 1'b1;
                r_pend_buttons <= i_buttons;
            end else if (i_grant) begin
                r_pending <= 1'b0;
            end

            // Set beats clear so a coincident overrun is never lost.
            if (w_capture && r_pending && !i_grant) begin
                r_overrun <= 1'b1;
            end else if (i_overrun_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    // Keepalive counter: saturating, restarted whenever this port is granted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ka_cnt <= '0;
        end else if (i_grant) begin
            r_ka_cnt <= '0;
        end else if (!w_ka_expired) begin
            r_ka_cnt <= r_ka_cnt + CNT_W'(1);
        end
    end

    assign o_pending      = r_pending;
    assign o_pend_buttons = r_pend_buttons;
    assign o_overrun      = r_overrun;

endmodule

// File: rtl/controller_report_arbiter.sv
// Merges two controller reader streams into one valid/ready report channel
// with change filtering, keepalive resend and round-robin arbitration.
module controller_report_arbiter
    import controller_pkg::*;
#(
    parameter int KEEPALIVE_CYCLES = KEEPALIVE_DEFAULT,
    parameter int CNT_W            = $clog2(KEEPALIVE_CYCLES + 1)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        p0_valid,
    input  buttons_t                    p0_buttons,
    input  logic                        p1_valid,
    input  buttons_t                    p1_buttons,
    input  logic                        overrun_clr,
    output logic [NUM_PORTS-1:0]        overrun,
    controller_report_arbiter_if.master m
);

    arb_state_t r_state;
    arb_state_t w_state_next;

    logic     r_ptr;
    logic     r_m_valid;
    logic     r_m_port;
    buttons_t r_m_buttons;

    logic [NUM_PORTS-1:0] w_in_valid;
    buttons_t             w_in_buttons   [NUM_PORTS];
    logic [NUM_PORTS-1:0] w_pending;
    buttons_t             w_pend_buttons [NUM_PORTS];
    logic [NUM_PORTS-1:0] w_grant;
    logic                 w_grant_port;

    assign w_in_valid      = {p1_valid, p0_valid};
    assign w_in_buttons[0] = p0_buttons;
    assign w_in_buttons[1] = p1_buttons;

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_slot
        report_slot #(
            .KEEPALIVE_CYCLES (KEEPALIVE_CYCLES),
            .CNT_W            (CNT_W)
        ) u_slot (
            .clk            (clk),
            .rst_n          (rst_n),
            .i_valid        (w_in_valid[g]),
            .i_buttons      (w_in_buttons[g]),
            .i_grant        (w_grant[g]),
            .i_overrun_clr  (overrun_clr),
            .o_pending      (w_pending[g]),
            .o_pend_buttons (w_pend_buttons[g]),
            .o_overrun      (overrun[g])
        );
    end

    // Arbiter state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and grant selection; grants only from IDLE, so every report
    // is followed by at least one idle cycle.
    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned (no latch).
        w_state_next = r_state;
        w_grant      = '0;
        w_grant_port = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                if (|w_pending) begin
                    if (w_pending[0] && w_pending[1]) begin
                        w_grant_port = r_ptr;
                    end else begin
                        w_grant_port = w_pending[1];
                    end
                    w_grant      = NUM_PORTS'(1) << w_grant_port;
                    w_state_next = ARB_PRESENT;
                end
            end
            ARB_PRESENT: begin
                if (r_m_valid && m.m_ready) begin
                    w_state_next = ARB_IDLE;
                end
            end
            default: w_state_next = ARB_IDLE;
        endcase
    end

    // Output report registers and round-robin pointer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_m_valid   <= 1'b0;
            r_m_port    <= 1'b0;
            r_m_buttons <= '0;
            r_ptr       <= 1'b0;
        end else if (|w_grant) begin
            r_m_valid   <= 1'b1;
            r_m_port    <= w_grant_port;
            r_m_buttons <= w_pend_buttons[w_grant_port];
            r_ptr       <= ~w_grant_port;
        end else if (r_m_valid && m.m_ready) begin
            r_m_valid <= 1'b0;
        end
    end

    assign m.m_valid   = r_m_valid;
    assign m.m_port    = r_m_port;
    assign m.m_buttons = r_m_buttons;

endmodule

// File: tb/tb_controller_report_arbiter.sv
// Directed bench for controller_report_arbiter with hand-computed expectations.
module tb_controller_report_arbiter;
    import controller_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       p0_valid;
    buttons_t   p0_buttons;
    logic       p1_valid;
    buttons_t   p1_buttons;
    logic       overrun_clr;
    logic [1:0] overrun;

    int n_checks = 0;
    int n_errors = 0;
    logic [8:0] log_q[$];   // {port, buttons} of every completed handshake
    logic       stable;

    controller_report_arbiter_if m_if ();

    controller_report_arbiter #(
        .KEEPALIVE_CYCLES (1000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .p0_valid    (p0_valid),
        .p0_buttons  (p0_buttons),
        .p1_valid    (p1_valid),
        .p1_buttons  (p1_buttons),
        .overrun_clr (overrun_clr),
        .overrun     (overrun),
        .m           (m_if)
    );

    always #5 clk = ~clk;

    // Record every accepted report.
    always @(posedge clk) begin
        if (rst_n && m_if.m_valid && m_if.m_ready) begin
            log_q.push_back({m_if.m_port, m_if.m_buttons});
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [8:0] log_at(input int idx);
        if (idx < log_q.size()) return log_q[idx];
        return 9'h1FF;
    endfunction

    task automatic pulse_p0(input buttons_t b);
        p0_buttons = b;
        p0_valid   = 1'b1;
        tick();
        p0_valid   = 1'b0;
        tick();
    endtask

    task automatic pulse_p1(input buttons_t b);
        p1_buttons = b;
        p1_valid   = 1'b1;
        tick();
        p1_valid   = 1'b0;
        tick();
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        p0_valid    = 1'b0;
        p0_buttons  = '0;
        p1_valid    = 1'b0;
        p1_buttons  = '0;
        overrun_clr = 1'b0;
        m_if.m_ready = 1'b0;
        tick(3);
        check("rst_valid",   32'(m_if.m_valid),   0);
        check("rst_port",    32'(m_if.m_port),    0);
        check("rst_buttons", 32'(m_if.m_buttons), 0);
        check("rst_overrun", 32'(overrun),        0);
        rst_n = 1'b1;
        tick();

        // Single frame: m_valid two edges after the rising valid.
        m_if.m_ready = 1'b1;
        p0_buttons   = 8'h80;
        p0_valid     = 1'b1;
        tick();
        check("lat_n1_valid", 32'(m_if.m_valid), 0);
        tick();
        check("lat_n2_valid",   32'(m_if.m_valid),   1);
        check("lat_n2_port",    32'(m_if.m_port),    0);
        check("lat_n2_buttons", 32'(m_if.m_buttons), 32'h80);
        tick();
        check("hs_valid_low", 32'(m_if.m_valid), 0);
        tick(10);                  // valid held high: still one frame
        p0_valid = 1'b0;
        tick();
        check("one_report", 32'(log_q.size()), 1);

        // Unchanged frame before keepalive is filtered; after expiry it resends.
        pulse_p0(8'h80);
        tick(10);
        check("unchanged_drop", 32'(log_q.size()), 1);
        tick(1010);
        pulse_p0(8'h80);
        tick(5);
        check("ka_count",  32'(log_q.size()), 2);
        check("ka_report", 32'(log_at(1)),    32'h080);

        // Simultaneous frames alternate fairly starting from port 0.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        p0_buttons = 8'h01; p1_buttons = 8'h02;
        p0_valid   = 1'b1;  p1_valid   = 1'b1;
        tick();
        p0_valid = 1'b0; p1_valid = 1'b0;
        tick(8);
        check("rr1_first",  32'(log_at(2)), 32'h001);
        check("rr1_second", 32'(log_at(3)), 32'h102);
        p0_buttons = 8'h03; p1_buttons = 8'h04;
        p0_valid   = 1'b1;  p1_valid   = 1'b1;
        tick();
        p0_valid = 1'b0; p1_valid = 1'b0;
        tick(8);
        check("rr2_first",  32'(log_at(4)), 32'h003);
        check("rr2_second", 32'(log_at(5)), 32'h104);

        // Backpressure: report held stable, single handshake on release.
        m_if.m_ready = 1'b0;
        pulse_p0(8'h05);
        check("stall_valid", 32'(m_if.m_valid), 1);
        stable = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (m_if.m_valid !== 1'b1 || m_if.m_port !== 1'b0 || m_if.m_buttons !== 8'h05)
                stable = 1'b0;
        end
        check("stall_stable", 32'(stable), 1);
        m_if.m_ready = 1'b1;
        tick();
        check("stall_release_low", 32'(m_if.m_valid), 0);
        check("stall_count",       32'(log_q.size()), 7);
        check("stall_report",      32'(log_at(6)),    32'h005);

        // Overrun: p0 overwritten twice while p1 report is blocked.
        m_if.m_ready = 1'b0;
        pulse_p1(8'h06);
        check("ovr_present_port", 32'(m_if.m_port), 1);
        pulse_p0(8'h10);
        pulse_p0(8'h20);
        check("ovr_set", 32'(overrun), 32'b01);
        m_if.m_ready = 1'b1;
        tick(8);
        check("ovr_p1_sent", 32'(log_at(7)),    32'h106);
        check("ovr_p0_sent", 32'(log_at(8)),    32'h020);
        check("ovr_count",   32'(log_q.size()), 9);
        check("ovr_sticky",  32'(overrun),      32'b01);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        check("ovr_clr", 32'(overrun), 0);

        // Reset while presenting with both ports pending.
        m_if.m_ready = 1'b0;
        p0_buttons = 8'h30; p1_buttons = 8'h40;
        p0_valid   = 1'b1;  p1_valid   = 1'b1;
        tick();
        p0_valid = 1'b0; p1_valid = 1'b0;
        tick();
        check("mid_valid", 32'(m_if.m_valid), 1);
        check("mid_port",  32'(m_if.m_port),  1);
        pulse_p1(8'h41);
        rst_n = 1'b0;
        tick();
        check("mid_rst_valid",   32'(m_if.m_valid),   0);
        check("mid_rst_port",    32'(m_if.m_port),    0);
        check("mid_rst_buttons", 32'(m_if.m_buttons), 0);
        check("mid_rst_overrun", 32'(overrun),        0);
        rst_n = 1'b1;
        m_if.m_ready = 1'b1;
        tick(10);
        check("post_rst_quiet", 32'(log_q.size()), 9);
        pulse_p0(8'h00);
        tick(10);
        check("post_rst_zero_drop", 32'(log_q.size()), 9);
        pulse_p0(8'h22);
        tick(6);
        check("post_rst_count",  32'(log_q.size()), 10);
        check("post_rst_report", 32'(log_at(9)),    32'h022);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
